// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch front end.
package if_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Response buffer for fetched {pc, instr} entries; head is read combinationally.
// Clear has priority over push/pop so a redirect flushes the whole buffer in one cycle.
module fetch_fifo
    import if_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          clear,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload storage needs no reset: entries are only visible while count says so.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited imem requests, squash of stale responses.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t          state;
    logic            fetch_en;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   kill;
    logic [OW-1:0]   outstanding_after_rsp;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CW:0]     credits_used;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            issue;
    logic            rsp_in;
    logic            accept;
    logic            pop;
    logic [XLEN-1:0] target;

    // A request is only made when its response is guaranteed a buffer slot.
    assign credits_used   = (CW+1)'(outstanding) + (CW+1)'(fifo_count);
    assign imem_req_valid = fetch_en && !redirect_valid
                            && (outstanding < OW'(MAX_OUTSTANDING))
                            && (credits_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = req_pc;

    assign issue  = imem_req_valid && imem_req_ready;
    assign rsp_in = imem_rsp_valid && (outstanding != '0);
    assign accept = rsp_in && (state == FETCH) && !redirect_valid;
    assign pop    = out_valid && out_ready;
    assign target = redirect_pc & ~32'h3;

    assign outstanding_after_rsp = outstanding - OW'(rsp_in);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            fetch_en    <= 1'b0;
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            kill        <= '0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding_after_rsp + OW'(issue);
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                req_pc <= target;
                rsp_pc <= target;
                kill   <= outstanding_after_rsp;
                state  <= (outstanding_after_rsp != '0) ? DRAIN : FETCH;
            end else begin
                if (issue)  req_pc <= req_pc + PC_STEP;
                if (accept) rsp_pc <= rsp_pc + PC_STEP;
                if (rsp_in && state == DRAIN) begin
                    kill <= kill - 1'b1;
                    if (kill == OW'(1)) state <= FETCH;
                end
            end
        end
    end

    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept && (!fifo_full || pop)),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (redirect_valid),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_empty ? '0 : head.pc;
    assign out_instr = fifo_empty ? NOP_INSTR : head.instr;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop)                    perf_fetched <= perf_fetched + 32'd1;
            if (out_valid && !out_ready) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif
endmodule
